// File: rtl/filt_pkg.sv
// Shared helpers and FSM encoding for the time-multiplexed FIR filter family.
package filt_pkg;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int p = 1; p < v; p = p * 2) r++;
        return r;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Symmetric filters only store the first half of the impulse response.
    function automatic int taps(input int len, input int symm);
        return (symm != 0) ? ceil_div(len, 2) : len;
    endfunction

    function automatic int acc_w(input int dw, input int cw, input int symm, input int len);
        return dw + cw + symm + clog2(len);
    endfunction

    localparam logic [1:0] ST_CLEAR = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_MAC   = 2'd2;
    localparam logic [1:0] ST_OUT   = 2'd3;

endpackage

// File: rtl/filt_rnd_sat.sv
// Combinational arithmetic right shift with round-half-up, then signed saturation.
module filt_rnd_sat #(
    parameter int gp_in_width  = 22,
    parameter int gp_out_width = 22,
    parameter int gp_frac      = 0
) (
    input  logic signed [gp_in_width-1:0]  din,
    output logic signed [gp_out_width-1:0] dout,
    output logic                           sat
);
    // One guard bit keeps the rounding increment from overflowing.
    localparam int W = gp_in_width + 1;

    logic signed [W-1:0] r;

    generate
        if (gp_frac > 0) begin : g_round
            localparam logic signed [W-1:0] HALF = W'(1) << (gp_frac - 1);
            assign r = (W'(din) + HALF) >>> gp_frac;
        end else begin : g_pass
            assign r = W'(din);
        end

        if (gp_out_width >= W) begin : g_wide
            assign dout = gp_out_width'(r);
            assign sat  = 1'b0;
        end else begin : g_clip
            logic [W-gp_out_width:0] top;
            logic                    fits;
            assign top  = r[W-1:gp_out_width-1];
            assign fits = (&top) | ~(|top);
            assign sat  = ~fits;
            assign dout = fits     ? r[gp_out_width-1:0] :
                          r[W-1]   ? {1'b1, {(gp_out_width-1){1'b0}}} :
                                     {1'b0, {(gp_out_width-1){1'b1}}};
        end
    endgenerate

endmodule

// File: rtl/filt_fir_mac.sv
// Multi-channel FIR sharing one multiply-accumulate unit across taps and channels.
module filt_fir_mac
    import filt_pkg::*;
#(
    parameter int gp_data_width   = 8,
    parameter int gp_coeff_width  = 8,
    parameter int gp_coeff_length = 17,
    parameter int gp_channels     = 2,
    parameter int gp_symm         = 1,
    parameter int gp_frac         = 0,
    parameter int gp_oup_width    = gp_data_width + gp_coeff_width + 1 + $clog2(gp_coeff_length)
) (
    input  logic                                                        i_clk,
    input  logic                                                        i_rst,
    input  logic                                                        i_valid,
    output logic                                                        o_ready,
    input  logic [max2(1, clog2(gp_channels))-1:0]                      i_chan,
    input  logic signed [gp_data_width-1:0]                             i_data,
    input  logic                                                        i_coeff_we,
    input  logic [max2(1, clog2(taps(gp_coeff_length, gp_symm)))-1:0]   i_coeff_addr,
    input  logic signed [gp_coeff_width-1:0]                            i_coeff_data,
    output logic                                                        o_valid,
    output logic [max2(1, clog2(gp_channels))-1:0]                      o_chan,
    output logic signed [gp_oup_width-1:0]                              o_data,
    output logic                                                        o_sat
);
    localparam int L      = gp_coeff_length;
    localparam int c_taps = taps(L, gp_symm);
    localparam int c_acc  = acc_w(gp_data_width, gp_coeff_width, gp_symm, L);
    localparam int c_chw  = max2(1, clog2(gp_channels));
    localparam int c_aw   = max2(1, clog2(c_taps));
    localparam int c_pw   = max2(1, clog2(L));
    localparam int c_clr  = max2(gp_channels * L, c_taps);
    localparam int c_cw   = max2(1, clog2(c_clr + 1));
    localparam int c_pre  = gp_data_width + gp_symm;
    localparam int c_prw  = gp_coeff_width + c_pre;
    localparam bit c_mid  = (gp_symm != 0) && (L % 2 == 1);

    logic [1:0]                       state;
    logic signed [gp_data_width-1:0]  dline [gp_channels][L];
    logic signed [gp_coeff_width-1:0] coeff [c_taps];
    logic [c_pw-1:0]                  ptr   [gp_channels];
    logic [c_pw-1:0]                  idx_a, idx_b;
    logic [c_aw-1:0]                  tap;
    logic [c_chw-1:0]                 cur_ch;
    logic signed [c_acc-1:0]          acc;
    logic [c_cw-1:0]                  clr_cnt;
    logic [c_chw-1:0]                 clr_ch;
    logic [c_pw-1:0]                  clr_idx;
    logic                             chan_ok;
    logic signed [gp_data_width-1:0]  xa, xb;
    logic signed [c_pre-1:0]          pre;
    logic signed [c_prw-1:0]          prod;
    logic signed [gp_oup_width-1:0]   rs_data;
    logic                             rs_sat;

    function automatic logic [c_pw-1:0] inc(input logic [c_pw-1:0] p);
        return (p == c_pw'(L - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [c_pw-1:0] dec(input logic [c_pw-1:0] p);
        return (p == '0) ? c_pw'(L - 1) : p - 1'b1;
    endfunction

    assign o_ready = (state == ST_IDLE);
    assign chan_ok = (int'(i_chan) < gp_channels);

    // idx_a walks back from the newest sample, idx_b forward from the oldest.
    assign xa = dline[cur_ch][idx_a];
    assign xb = dline[cur_ch][idx_b];

    always_comb begin
        pre = c_pre'(xa);
        if (gp_symm != 0 && !(c_mid && tap == c_aw'(c_taps - 1)))
            pre = c_pre'(xa) + c_pre'(xb);
    end

    assign prod = c_prw'(coeff[tap]) * c_prw'(pre);

    filt_rnd_sat #(
        .gp_in_width (c_acc),
        .gp_out_width(gp_oup_width),
        .gp_frac     (gp_frac)
    ) u_rnd_sat (
        .din (acc),
        .dout(rs_data),
        .sat (rs_sat)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
            clr_ch  <= '0;
            clr_idx <= '0;
            tap     <= '0;
            acc     <= '0;
            cur_ch  <= '0;
            idx_a   <= '0;
            idx_b   <= '0;
            o_valid <= 1'b0;
            o_data  <= '0;
            o_chan  <= '0;
            o_sat   <= 1'b0;
            for (int i = 0; i < gp_channels; i++) ptr[i] <= '0;
        end else begin
            o_valid <= 1'b0;
            case (state)
                ST_CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_idx == c_pw'(L - 1)) begin
                        clr_idx <= '0;
                        clr_ch  <= clr_ch + 1'b1;
                    end else begin
                        clr_idx <= clr_idx + 1'b1;
                    end
                    if (clr_cnt == c_cw'(c_clr - 1)) state <= ST_IDLE;
                end
                ST_IDLE: begin
                    // Out-of-range channels are consumed without starting a computation.
                    if (i_valid && chan_ok) begin
                        ptr[i_chan] <= inc(ptr[i_chan]);
                        cur_ch      <= i_chan;
                        idx_a       <= ptr[i_chan];
                        idx_b       <= inc(ptr[i_chan]);
                        tap         <= '0;
                        acc         <= '0;
                        state       <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    acc   <= acc + c_acc'(prod);
                    idx_a <= dec(idx_a);
                    idx_b <= inc(idx_b);
                    tap   <= tap + 1'b1;
                    if (tap == c_aw'(c_taps - 1)) state <= ST_OUT;
                end
                ST_OUT: begin
                    o_valid <= 1'b1;
                    o_data  <= rs_data;
                    o_chan  <= cur_ch;
                    o_sat   <= rs_sat;
                    state   <= ST_IDLE;
                end
                default: state <= ST_CLEAR;
            endcase
        end
    end

    // Storage has no reset; CLEAR walks through it one word per cycle instead.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            if (state == ST_CLEAR) begin
                if (clr_cnt < c_cw'(gp_channels * L)) dline[clr_ch][clr_idx] <= '0;
                if (clr_cnt < c_cw'(c_taps)) coeff[clr_cnt[c_aw-1:0]] <= '0;
            end else if (state == ST_IDLE) begin
                if (i_coeff_we && int'(i_coeff_addr) < c_taps) coeff[i_coeff_addr] <= i_coeff_data;
                if (i_valid && chan_ok) dline[i_chan][ptr[i_chan]] <= i_data;
            end
        end
    end

endmodule

// File: tb/tb_filt_fir_mac.sv
// Scoreboard bench: three filter configurations, directed vectors, queue-based output checking.
module tb_filt_fir_mac;

    localparam int C_TAPS = 9;

    typedef struct {
        int     ch;
        longint d;
        bit     s;
        int     due;
    } exp_t;

    logic              clk = 1'b0;
    logic [2:0]        rst, vld, we;
    logic [1:0]        chan;
    logic signed [7:0] din, cdat;
    logic [3:0]        caddr;
    wire  [2:0]        rdy, ov;
    logic signed [21:0] da, dc;
    logic signed [15:0] db;
    logic              ca, cb;
    logic [1:0]        cc;
    logic              sa, sb, sc;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t qa[$], qb[$], qc[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    filt_fir_mac u_a (
        .i_clk(clk), .i_rst(rst[0]), .i_valid(vld[0]), .o_ready(rdy[0]),
        .i_chan(chan[0]), .i_data(din), .i_coeff_we(we[0]), .i_coeff_addr(caddr),
        .i_coeff_data(cdat), .o_valid(ov[0]), .o_chan(ca), .o_data(da), .o_sat(sa)
    );

    filt_fir_mac #(.gp_oup_width(16), .gp_frac(0)) u_b (
        .i_clk(clk), .i_rst(rst[1]), .i_valid(vld[1]), .o_ready(rdy[1]),
        .i_chan(chan[0]), .i_data(din), .i_coeff_we(we[1]), .i_coeff_addr(caddr),
        .i_coeff_data(cdat), .o_valid(ov[1]), .o_chan(cb), .o_data(db), .o_sat(sb)
    );

    filt_fir_mac #(.gp_frac(2), .gp_channels(3)) u_c (
        .i_clk(clk), .i_rst(rst[2]), .i_valid(vld[2]), .o_ready(rdy[2]),
        .i_chan(chan), .i_data(din), .i_coeff_we(we[2]), .i_coeff_addr(caddr),
        .i_coeff_data(cdat), .o_valid(ov[2]), .o_chan(cc), .o_data(dc), .o_sat(sc)
    );

    task automatic cmp(input string name, input logic signed [63:0] got, input logic signed [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    task automatic wait_ready(input int d);
        int n = 0;
        @(negedge clk);
        while (rdy[d] !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (rdy[d] !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout dut %0d got 0 want 1", d);
        end
    endtask

    task automatic wcoef(input int d, input int a, input int v);
        wait_ready(d);
        we[d] = 1'b1;
        caddr = 4'(a);
        cdat  = 8'(v);
        @(posedge clk);
        #1;
        we[d] = 1'b0;
    endtask

    task automatic send(input int d, input int ch, input int x, input bit ex, input longint ed, input bit es);
        exp_t e;
        wait_ready(d);
        chan   = 2'(ch);
        din    = 8'(x);
        vld[d] = 1'b1;
        @(posedge clk);
        #1;
        vld[d] = 1'b0;
        we     = '0;
        if (ex) begin
            e.ch = ch; e.d = ed; e.s = es; e.due = cyc + C_TAPS + 1;
            case (d)
                0:       qa.push_back(e);
                1:       qb.push_back(e);
                default: qc.push_back(e);
            endcase
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (ov[0] === 1'b1) begin
            if (qa.size() == 0) begin
                checks++; errors++;
                $display("FAIL a_spurious_valid got data %0d want no output", da);
            end else begin
                e = qa.pop_front();
                cmp("a_data", da, e.d); cmp("a_chan", ca, e.ch);
                cmp("a_sat", sa, e.s);  cmp("a_latency", cyc, e.due);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (ov[1] === 1'b1) begin
            if (qb.size() == 0) begin
                checks++; errors++;
                $display("FAIL b_spurious_valid got data %0d want no output", db);
            end else begin
                e = qb.pop_front();
                cmp("b_data", db, e.d); cmp("b_chan", cb, e.ch);
                cmp("b_sat", sb, e.s);  cmp("b_latency", cyc, e.due);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (ov[2] === 1'b1) begin
            if (qc.size() == 0) begin
                checks++; errors++;
                $display("FAIL c_spurious_valid got data %0d want no output", dc);
            end else begin
                e = qc.pop_front();
                cmp("c_data", dc, e.d); cmp("c_chan", cc, e.ch);
                cmp("c_sat", sc, e.s);  cmp("c_latency", cyc, e.due);
            end
        end
    end

    initial begin
        int n;
        rst = '1; vld = '0; we = '0; chan = '0; din = '0; caddr = '0; cdat = '0;
        repeat (3) @(negedge clk);
        cmp("rst_ready", rdy, 0);
        cmp("rst_valid", ov, 0);
        cmp("rst_data_a", da, 0);
        cmp("rst_data_b", db, 0);
        cmp("rst_data_c", dc, 0);
        cmp("rst_chan", {ca, cb, cc}, 0);
        cmp("rst_sat", {sa, sb, sc}, 0);
        rst = '0;
        n = 0;
        while (rdy[0] !== 1'b1 && n < 200) begin n++; @(negedge clk); end
        cmp("a_clear_cycles", n, 34);

        // Impulse response of the 17-tap symmetric filter built from c[k]=k+1.
        for (int k = 0; k < 9; k++) wcoef(0, k, k + 1);
        for (int m = 0; m < 17; m++) send(0, 0, (m == 0) ? 1 : 0, 1, (m <= 8) ? m + 1 : 17 - m, 0);

        // Interleaved channels must stay independent.
        for (int r = 0; r < 6; r++) begin
            send(0, 0, (r == 0) ? 1 : 0, 1, r + 1, 0);
            send(0, 1, (r == 0) ? 5 : 0, 1, 5 * (r + 1), 0);
        end

        // ch0 history now holds 1 at x[n-5]; a write during MAC must be dropped.
        send(0, 0, 2, 1, 9, 0);
        @(negedge clk);
        cmp("a_busy_in_mac", rdy[0], 0);
        we[0] = 1'b1; caddr = 4'd0; cdat = 8'sd100;
        @(posedge clk);
        #1;
        we[0] = 1'b0;
        send(0, 0, 3, 1, 15, 0);

        // Reset in the middle of a computation aborts it and clears history.
        send(0, 0, 7, 0, 0, 0);
        repeat (3) @(negedge clk);
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        n = 0;
        while (rdy[0] !== 1'b1 && n < 200) begin n++; @(negedge clk); end
        cmp("a_reclear_cycles", n, 34);
        for (int k = 0; k < 9; k++) wcoef(0, k, k + 1);
        send(0, 0, 3, 1, 3, 0);
        send(0, 0, 0, 1, 6, 0);
        send(0, 1, 0, 1, 0, 0);
        send(0, 1, 4, 1, 4, 0);

        // 16-bit output: positive and negative saturation boundaries.
        for (int k = 0; k < 9; k++) wcoef(1, k, 127);
        for (int m = 0; m < 17; m++)
            send(1, 0, 127, 1, (m == 0) ? 16129 : (m == 1) ? 32258 : 32767, m >= 2);
        for (int m = 0; m < 3; m++)
            send(1, 1, -128, 1, (m == 0) ? -16256 : (m == 1) ? -32512 : -32768, m == 2);

        // Rounding with two fractional bits; out-of-range channel is discarded.
        send(2, 3, 99, 0, 0, 0);
        cmp("c_discard_ready", rdy[2], 1);
        we[2] = 1'b1; caddr = 4'd0; cdat = 8'sd6;
        send(2, 0, 1, 1, 2, 0);
        send(2, 0, -1, 1, -1, 0);
        send(2, 2, -2, 1, -3, 0);

        n = 0;
        while ((qa.size() + qb.size() + qc.size()) != 0 && n < 200) begin n++; @(negedge clk); end
        repeat (3) @(negedge clk);
        cmp("queues_drained", qa.size() + qb.size() + qc.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
